arbiter_rr: RTL and testbench

Registered round-robin arbiter sharing one resource between `NUM_REQ` requesters, with grant hold and a bounded hold quantum. It is the DUT behind the arbiter interface: it consumes the `request` vector and drives the one-hot `grant` vector. The TEST, DUT and MONITOR views all connect to it unchanged.

---
 rtl/arbiter_pkg.sv | 15 +
 rtl/rr_pick.sv | 34 +++
 rtl/arbiter_rr.sv | 87 ++++++++
 tb/tb_arbiter_rr.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// The one-hot helper returns a wide vector; callers cast it down to their own width.
package arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam int ARB_NUM_REQ   = 2;
  localparam int ARB_MAX_HOLD  = 8;
  localparam int ARB_MAX_WIDTH = 32;

  function automatic logic [ARB_MAX_WIDTH-1:0] onehot(input int unsigned idx);
    return ARB_MAX_WIDTH'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: rotate the eligible requests so the slot after 'last' lands at bit 0,
// then priority-encode the lowest set bit and rotate the index back.
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         request,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  input  logic [NUM_REQ-1:0]         exclude,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_masked;
  logic [NUM_REQ-1:0] w_rotated;
  logic [IDX_W-1:0]   w_start;

  assign w_masked  = request & ~exclude;
  assign w_start   = (last == IDX_W'(NUM_REQ - 1)) ? '0 : last + 1'b1;
  assign w_rotated = NUM_REQ'({w_masked, w_masked} >> w_start);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rotated[k]) begin
        found = 1'b1;
        idx   = IDX_W'((32'(w_start) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/arbiter_rr.sv
// Registered round-robin arbiter with grant hold and an optional hold quantum
// (MAX_HOLD = 0 disables preemption).
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int NUM_REQ  = ARB_NUM_REQ,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         request,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_last;
  logic [HOLD_W-1:0]  r_holdCnt;

  logic [NUM_REQ-1:0] w_exclude;
  logic               w_found;
  logic [IDX_W-1:0]   w_pickIdx;
  logic               w_ownerReq;
  logic               w_quantumUp;

  // While granted, the owner is masked out so both release and preemption pick another requester.
  assign w_exclude   = (r_state == ARB_GRANT) ? NUM_REQ'(onehot(32'(r_owner))) : '0;
  assign w_ownerReq  = request[r_owner];
  assign w_quantumUp = (MAX_HOLD != 0) && (r_holdCnt == HOLD_MAX);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .request (request),
    .last    (r_last),
    .exclude (w_exclude),
    .found   (w_found),
    .idx     (w_pickIdx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ARB_IDLE;
      r_owner   <= '0;
      r_last    <= LAST_RST;
      r_holdCnt <= '0;
      grant     <= '0;
      grant_id  <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            grant     <= NUM_REQ'(onehot(32'(w_pickIdx)));
            grant_id  <= w_pickIdx;
            r_owner   <= w_pickIdx;
            r_last    <= w_pickIdx;
            r_holdCnt <= HOLD_W'(1);
            r_state   <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // Release and quantum expiry both hand over directly to the next winner, no idle gap.
          if (w_found && (!w_ownerReq || w_quantumUp)) begin
            grant     <= NUM_REQ'(onehot(32'(w_pickIdx)));
            grant_id  <= w_pickIdx;
            r_owner   <= w_pickIdx;
            r_last    <= w_pickIdx;
            r_holdCnt <= HOLD_W'(1);
          end else if (!w_ownerReq) begin
            grant     <= '0;
            grant_id  <= '0;
            r_holdCnt <= '0;
            r_state   <= ARB_IDLE;
          end else if ((MAX_HOLD != 0) && (r_holdCnt != HOLD_MAX)) begin
            r_holdCnt <= r_holdCnt + 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_rr.sv
// Self-checking bench for arbiter_rr: a 2-requester instance with quantum 8 and a
// 4-requester instance with preemption disabled, checked through an expected-value queue.
module tb_arbiter_rr;

  logic       clk;
  logic       rst2;
  logic       rst4;
  logic [1:0] req2;
  logic [1:0] grant2;
  logic [0:0] id2;
  logic [3:0] req4;
  logic [3:0] grant4;
  logic [1:0] id4;
  logic [1:0] prev2;
  logic [3:0] prev4;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] grant;
    logic       id;
  } vec2_t;

  typedef struct {
    logic       wide;
    logic [3:0] grant;
    logic [1:0] id;
    string      name;
  } exp_t;

  exp_t  expQ[$];
  vec2_t vecs[17];

  arbiter_rr #(.NUM_REQ(2), .MAX_HOLD(8)) dut2 (
    .clk      (clk),
    .rst      (rst2),
    .request  (req2),
    .grant    (grant2),
    .grant_id (id2)
  );

  arbiter_rr #(.NUM_REQ(4), .MAX_HOLD(0)) dut4 (
    .clk      (clk),
    .rst      (rst4),
    .request  (req4),
    .grant    (grant4),
    .grant_id (id4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  always @(posedge clk) begin
    prev2 <= req2;
    prev4 <= req4;
  end

  // Per-cycle invariants: one-hot-or-zero, grant_id matches, and no grant without a prior request.
  always @(negedge clk) begin
    if (!$isunknown(prev2) && !$isunknown(prev4)) begin
      checks++;
      if (!$onehot0(grant2) || (grant2 != 0 && !grant2[id2]) || ((grant2 & ~prev2) != 0)) begin
        errors++;
        $display("[TB] FAIL invariant2: grant=%b id=%0d prevReq=%b", grant2, id2, prev2);
      end
      checks++;
      if (!$onehot0(grant4) || (grant4 != 0 && !grant4[id4]) || ((grant4 & ~prev4) != 0)) begin
        errors++;
        $display("[TB] FAIL invariant4: grant=%b id=%0d prevReq=%b", grant4, id4, prev4);
      end
    end
  end

  task automatic applyStimulus(input logic wide, input logic r, input logic [3:0] req,
                               input logic [3:0] g, input logic [1:0] id, input string name);
    exp_t e;
    @(negedge clk);
    if (wide) begin
      rst4 = r;
      req4 = req;
    end else begin
      rst2 = r;
      req2 = req[1:0];
    end
    e.wide  = wide;
    e.grant = g;
    e.id    = id;
    e.name  = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [3:0] ag;
    logic [1:0] aid;
    @(posedge clk);
    #1;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: no expected entry queued");
      return;
    end
    e   = expQ.pop_front();
    ag  = e.wide ? grant4 : {2'b00, grant2};
    aid = e.wide ? id4 : {1'b0, id2};
    if (ag !== e.grant || aid !== e.id) begin
      errors++;
      $display("[TB] FAIL %s: got grant=%b id=%0d, expected grant=%b id=%0d",
               e.name, ag, aid, e.grant, e.id);
    end
  endtask

  task automatic step(input logic wide, input logic r, input logic [3:0] req,
                      input logic [3:0] g, input logic [1:0] id, input string name);
    applyStimulus(wide, r, req, g, id, name);
    checkOutput();
  endtask

  task automatic checkHold(input logic [3:0] want, input string name);
    checks++;
    if (dut2.r_holdCnt !== want) begin
      errors++;
      $display("[TB] FAIL %s: got hold_cnt=%0d, expected %0d", name, dut2.r_holdCnt, want);
    end
  endtask

  initial begin
    rst2 = 1'b0;
    rst4 = 1'b0;
    req2 = '0;
    req4 = '0;

    vecs[0]  = '{1'b0, 2'b11, 2'b00, 1'b0};
    vecs[1]  = '{1'b1, 2'b11, 2'b01, 1'b0};
    vecs[2]  = '{1'b1, 2'b11, 2'b01, 1'b0};
    vecs[3]  = '{1'b1, 2'b10, 2'b10, 1'b1};
    vecs[4]  = '{1'b1, 2'b10, 2'b10, 1'b1};
    vecs[5]  = '{1'b1, 2'b00, 2'b00, 1'b0};
    vecs[6]  = '{1'b1, 2'b00, 2'b00, 1'b0};
    vecs[7]  = '{1'b1, 2'b01, 2'b01, 1'b0};
    vecs[8]  = '{1'b1, 2'b11, 2'b01, 1'b0};
    vecs[9]  = '{1'b1, 2'b01, 2'b01, 1'b0};
    vecs[10] = '{1'b1, 2'b11, 2'b01, 1'b0};
    vecs[11] = '{1'b1, 2'b00, 2'b00, 1'b0};
    vecs[12] = '{1'b1, 2'b10, 2'b10, 1'b1};
    vecs[13] = '{1'b1, 2'b11, 2'b10, 1'b1};
    vecs[14] = '{1'b0, 2'b11, 2'b00, 1'b0};
    vecs[15] = '{1'b1, 2'b11, 2'b01, 1'b0};
    vecs[16] = '{1'b1, 2'b00, 2'b00, 1'b0};

    for (int i = 0; i < 17; i++) begin
      step(1'b0, vecs[i].rst, {2'b00, vecs[i].req}, {2'b00, vecs[i].grant},
           {1'b0, vecs[i].id}, $sformatf("vec%0d", i));
      if (i == 0) checkHold(4'd0, "resetHold");
    end

    // Continuous contention: each side owns for exactly eight cycles.
    step(1'b0, 1'b0, 4'b0011, 4'b0000, 2'd0, "preReset");
    for (int n = 0; n < 30; n++) begin
      if (((n / 8) % 2) == 0)
        step(1'b0, 1'b1, 4'b0011, 4'b0001, 2'd0, $sformatf("preempt%0d", n));
      else
        step(1'b0, 1'b1, 4'b0011, 4'b0010, 2'd1, $sformatf("preempt%0d", n));
    end

    // Sole requester saturates the quantum but is never preempted; a late rival then wins at once.
    for (int n = 0; n < 20; n++)
      step(1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, $sformatf("sole%0d", n));
    checkHold(4'd8, "soleHoldSat");
    step(1'b0, 1'b1, 4'b0011, 4'b0010, 2'd1, "satPreempt");

    // Four requesters, no preemption: wrap-around from last winner 3.
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0, "w4Reset");
    step(1'b1, 1'b1, 4'b1000, 4'b1000, 2'd3, "w4Own3");
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, "w4Idle");
    step(1'b1, 1'b1, 4'b1010, 4'b0010, 2'd1, "wrapTo1");
    step(1'b1, 1'b1, 4'b1001, 4'b1000, 2'd3, "wrapTo3");
    for (int n = 0; n < 10; n++)
      step(1'b1, 1'b1, 4'b1001, 4'b1000, 2'd3, $sformatf("noPreempt%0d", n));
    step(1'b1, 1'b1, 4'b0001, 4'b0001, 2'd0, "w4To0");
    step(1'b1, 1'b1, 4'b0111, 4'b0001, 2'd0, "w4Keep0");
    step(1'b1, 1'b1, 4'b0110, 4'b0010, 2'd1, "w4To1");
    step(1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, "w4To2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
